uart_tx_scheduler: RTL

- Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers.
- Accepts a byte from the winning requester, launches the transmitter, and waits for frame completion.
- Enforces an inter-frame idle gap and a completion timeout, both counted in baud ticks.
- Sits between the system's byte sources and the existing transmitter; it consumes the same baud tick the receiver and transmitter use.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rr_pick.sv | 34 +++
 rtl/uart_tx_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART scheduling types, default frame constants and counter sizing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } sched_state_t;

  localparam int DEF_DATA_W        = 8;
  localparam int FRAME_BITS        = 10;  // start + 8 data + stop
  localparam int DEF_GAP_TICKS     = 2;
  localparam int DEF_TIMEOUT_TICKS = 12;

  // Width of a counter able to hold every value 0..max(a,b); never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to consume the winner.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic            any,
  output logic [ID_W-1:0] winner
);

  int              sum;
  logic [ID_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest set request overrides.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    sum    = 0;
    idx    = '0;
    for (int i = N; i >= 1; i--) begin
      sum = int'(last) + i;
      if (sum >= N) sum = sum - N;
      idx = ID_W'(sum);
      if (req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte producers with round-robin fairness.
// Latency: req_ready in the cycle valid is seen (when idle), tx_start one or more cycles later.
// Backpressure: holds in LAUNCH while tx_busy, no new grant until done/timeout plus idle gap.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int GAP_TICKS     = DEF_GAP_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      baud,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      clear_err,
  output logic [15:0]               frame_count
);

  localparam int CNT_W = cnt_width(GAP_TICKS, TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  sched_state_t    state, state_nxt;
  logic [ID_W-1:0] last;
  logic [CNT_W-1:0] tick_cnt;
  logic            pick_any;
  logic [ID_W-1:0] pick_id;
  logic            accept, launch, done_hit, to_hit;

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (req_valid),
    .last   (last),
    .any    (pick_any),
    .winner (pick_id)
  );

  assign busy = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the one-cycle strobes; ready is masked while reset is held so no byte is taken.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    tx_start  = 1'b0;
    accept    = 1'b0;
    launch    = 1'b0;
    done_hit  = 1'b0;
    to_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && pick_any && reset) begin
          accept             = 1'b1;
          req_ready[pick_id] = 1'b1;
          state_nxt          = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          launch    = 1'b1;
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          done_hit  = 1'b1;
          state_nxt = ST_GAP;
        end else if (baud && tick_cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (GAP_TICKS == 0 || (baud && tick_cnt == GAP_LAST)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture the granted byte and advance the round-robin pointer on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data  <= '0;
      grant_id <= '0;
      last     <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      tx_data  <= req_data[pick_id*DATA_W +: DATA_W];
      grant_id <= pick_id;
      last     <= pick_id;
    end
  end

  // Shared baud-tick counter: timeout in WAIT_DONE, idle gap in GAP; cleared at each phase entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            tick_cnt <= '0;
    else if (launch || done_hit || to_hit) tick_cnt <= '0;
    else if (baud && (state == ST_WAIT_DONE || state == ST_GAP))
      tick_cnt <= tick_cnt + 1'b1;
  end

  // Completed-frame counter and sticky timeout flag (a new timeout beats a clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (done_hit)       frame_count <= frame_count + 16'd1;
      if (to_hit)         timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

endmodule
